// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: opcodes, data width, command record
// and the output-side state encoding.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } alu_cmd_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. The head entry is presented combinationally and
// forced to zero when the FIFO is empty. The caller must never push when
// full nor pop when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  alu_cmd_t         wr_cmd,
  output alu_cmd_t         head_cmd,
  output logic [CNT_W-1:0] count
);

  alu_cmd_t         mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // One write-enabled register per entry; storage needs no reset because
  // the pointers and count define which entries are meaningful.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the incoming command when this entry is the write target.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wr_cmd;
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_cmd = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
  assign count    = count_reg;

endmodule

// File: rtl/alu_eightbit.sv
// Purely combinational 8-bit ALU. Shifts use the whole of operand B, so a
// shift distance of 8 or more produces zero.
module alu_eightbit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] res_o
);

  // Select the operation result for the current opcode.
  always_comb begin
    res_o = '0;
    case (alu_op_e'(op_i))
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_SLL:  res_o = a_i << b_i;
      OP_LSR:  res_o = a_i >> b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_EQL:  res_o = (a_i == b_i) ? DATA_W'(1) : '0;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: queues ALU commands, presents the head to an external
// combinational ALU and captures its result into a one-entry output
// register governed by a two-state valid/ready FSM.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [OP_W-1:0]   res_op_o,
  output logic [CNT_W-1:0]  count_o
);

  alu_cmd_t          push_cmd;
  alu_cmd_t          head_cmd;
  logic              push;
  logic              issue;
  out_state_e        state_reg;
  out_state_e        state_next;
  logic [DATA_W-1:0] res_data_reg;
  logic [OP_W-1:0]   res_op_reg;

  // Readiness depends only on occupancy, so a same-cycle pop never lets a
  // full FIFO accept another command.
  assign cmd_ready_o = (count_o != CNT_W'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;

  // The head moves into the result register whenever that register is free
  // or is being drained this cycle.
  assign issue = (count_o != '0) && ((state_reg == OUT_EMPTY) || res_ready_i);

  assign push_cmd = '{a: cmd_a_i, b: cmd_b_i, op: alu_op_e'(cmd_op_i)};

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (issue),
    .wr_cmd   (push_cmd),
    .head_cmd (head_cmd),
    .count    (count_o)
  );

  assign alu_a_o  = head_cmd.a;
  assign alu_b_o  = head_cmd.b;
  assign alu_op_o = head_cmd.op;

  // Next-state logic for the output register occupancy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OUT_EMPTY: if (issue) state_next = OUT_FULL;
      OUT_FULL:  if (res_ready_i && !issue) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  // Output-side state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result register: loads on issue, otherwise holds (stable under stall).
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_reg <= '0;
      res_op_reg   <= '0;
    end else if (issue) begin
      res_data_reg <= alu_res_i;
      res_op_reg   <= head_cmd.op;
    end
  end

  assign res_valid_o = (state_reg == OUT_FULL);
  assign res_data_o  = res_data_reg;
  assign res_op_o    = res_op_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage driven by alu_eightbit. A queue-based model of
// the stage runs in lockstep with the DUT; directed tables and sequences
// add fixed expectations on top.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [7:0]       cmd_a_i = '0;
  logic [7:0]       cmd_b_i = '0;
  logic [2:0]       cmd_op_i = '0;
  logic [7:0]       alu_a_o;
  logic [7:0]       alu_b_o;
  logic [2:0]       alu_op_o;
  logic [7:0]       alu_res_i;
  logic             res_valid_o;
  logic             res_ready_i = 1'b0;
  logic [7:0]       res_data_o;
  logic [2:0]       res_op_o;
  logic [CNT_W-1:0] count_o;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_op_i    (cmd_op_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_op_o    (res_op_o),
    .count_o     (count_o)
  );

  alu_eightbit u_alu (
    .a_i   (alu_a_o),
    .b_i   (alu_b_o),
    .op_i  (alu_op_o),
    .res_o (alu_res_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int a;
    int b;
    int op;
  } mcmd_t;

  mcmd_t m_q[$];
  int    sb_data[$];
  int    sb_op[$];
  bit    m_valid = 1'b0;
  int    m_data = 0;
  int    m_op = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_res = 0;

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (b >= 8) ? 0 : (a * (2 ** b)) % 256;
      3: return (b >= 8) ? 0 : a / (2 ** b);
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic v, input int a, input int b, input int op,
                       input logic rdy, input logic rst);
    bit pop_ok;
    bit push_ok;
    mcmd_t c;
    cmd_valid_i = v;
    cmd_a_i     = 8'(a);
    cmd_b_i     = 8'(b);
    cmd_op_i    = 3'(op);
    res_ready_i = rdy;
    reset       = rst;
    if (rst) begin
      m_q.delete();
      sb_data.delete();
      sb_op.delete();
      m_valid = 1'b0;
      m_data  = 0;
      m_op    = 0;
    end else begin
      if (m_valid && rdy) begin
        n_res++;
        $display("[TB] result %0d op=%0d data=%0d", n_res, res_op_o, res_data_o);
        chk("consume_data", int'(res_data_o), sb_data.pop_front());
        chk("consume_op", int'(res_op_o), sb_op.pop_front());
      end
      pop_ok  = (m_q.size() > 0) && (!m_valid || rdy);
      push_ok = v && (m_q.size() < DEPTH);
      if (pop_ok) begin
        c = m_q.pop_front();
        m_data  = ref_alu(c.a, c.b, c.op);
        m_op    = c.op;
        m_valid = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (push_ok) begin
        c.a = a; c.b = b; c.op = op;
        m_q.push_back(c);
        sb_data.push_back(ref_alu(a, b, op));
        sb_op.push_back(op);
      end
    end
    @(posedge clk);
    #1;
    chk("count", int'(count_o), m_q.size());
    chk("cmd_ready", int'(cmd_ready_o), (m_q.size() != DEPTH) ? 1 : 0);
    chk("res_valid", int'(res_valid_o), int'(m_valid));
    chk("res_data", int'(res_data_o), m_data);
    chk("res_op", int'(res_op_o), m_op);
    chk("alu_a", int'(alu_a_o), (m_q.size() > 0) ? m_q[0].a : 0);
    chk("alu_b", int'(alu_b_o), (m_q.size() > 0) ? m_q[0].b : 0);
    chk("alu_op", int'(alu_op_o), (m_q.size() > 0) ? m_q[0].op : 0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v;
    int   op;
    logic rdy;
    int   exp_valid;
    int   exp_data;
    int   exp_op;
    int   exp_count;
  } vec_t;

  vec_t tbl[10];
  int   res_exp[8] = '{8, 2, 40, 0, 1, 7, 6, 0};

  initial begin
    int accepted;
    bit done;
    int k;

    // Eight back-to-back commands A=5,B=3, ops 0..7, always ready.
    for (int i = 0; i < 10; i++) begin
      k = (i > 8) ? 8 : i;
      tbl[i].v         = (i < 8);
      tbl[i].op        = (i < 8) ? i : 0;
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = (i >= 1 && i <= 8) ? 1 : 0;
      tbl[i].exp_data  = (i == 0) ? 0 : res_exp[k-1];
      tbl[i].exp_op    = (i == 0) ? 0 : k - 1;
      tbl[i].exp_count = (i < 8) ? 1 : 0;
    end

    do_reset();
    // First cycle after reset release.
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("post_reset_ready", int'(cmd_ready_o), 1);
    chk("post_reset_valid", int'(res_valid_o), 0);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, 5, 3, tbl[i].op, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), int'(res_valid_o), tbl[i].exp_valid);
      chk($sformatf("tbl%0d_data", i), int'(res_data_o), tbl[i].exp_data);
      chk($sformatf("tbl%0d_op", i), int'(res_op_o), tbl[i].exp_op);
      chk($sformatf("tbl%0d_count", i), int'(count_o), tbl[i].exp_count);
    end

    // Back-pressure: fill while the result is stalled.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 5, 3, i, 1'b0, 1'b0);
    chk("stall_count", int'(count_o), 4);
    chk("stall_ready", int'(cmd_ready_o), 0);
    chk("stall_data", int'(res_data_o), 8);
    cycle(1'b1, 5, 3, 5, 1'b0, 1'b0);
    chk("stall_hold_count", int'(count_o), 4);
    chk("stall_hold_data", int'(res_data_o), 8);
    chk("stall_hold_valid", int'(res_valid_o), 1);
    // Full with simultaneous pop: push refused, count drops 4 -> 3.
    cycle(1'b1, 5, 3, 5, 1'b1, 1'b0);
    chk("full_pop_count", int'(count_o), 3);
    chk("full_pop_data", int'(res_data_o), 2);
    cycle(1'b1, 5, 3, 5, 1'b1, 1'b0);
    chk("retry_count", int'(count_o), 3);
    chk("retry_data", int'(res_data_o), 40);
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    chk("drain_count", int'(count_o), 0);
    chk("drain_valid", int'(res_valid_o), 0);
    chk("drain_sb_empty", sb_data.size(), 0);

    // Reset mid-operation with queued commands and a held result.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 9, 2, i, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count_o), 3);
    chk("pre_rst_valid", int'(res_valid_o), 1);
    cycle(1'b1, 1, 1, 0, 1'b0, 1'b1);
    chk("rst_count", int'(count_o), 0);
    chk("rst_valid", int'(res_valid_o), 0);
    chk("rst_data", int'(res_data_o), 0);
    chk("rst_ready", int'(cmd_ready_o), 1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst_after_ready", int'(cmd_ready_o), 1);
    chk("rst_after_valid", int'(res_valid_o), 0);

    // Random commands with random downstream readiness.
    accepted = 0;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      logic v;
      int   b;
      v = (accepted < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      if (v && (m_q.size() < DEPTH)) accepted++;
      cycle(v, int'($urandom_range(0, 255)), b, int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'b0);
      if (accepted == 20 && m_q.size() == 0 && !m_valid) done = 1'b1;
    end
    chk("random_done", int'(done), 1);
    chk("random_sb_empty", sb_data.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
